// File: rtl/add64_seq.sv
// Multi-cycle adder that feeds one 16-bit slice per cycle, LSB first, through a single carry-skip adder.
// Optional ADD64_SEQ_SUB_EN adds a 'sub' port for A-B (B inverted, carry-in forced to 1).

module cska16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic blk_c;
    logic rc;
    logic prop;

    // Four 4-bit ripple blocks; a fully propagating block forwards its carry-in directly.
    always_comb begin
        s     = 16'h0000;
        blk_c = cin;
        rc    = 1'b0;
        prop  = 1'b0;
        for (int blk = 0; blk < 4; blk++) begin
            rc   = blk_c;
            prop = &(a[4*blk +: 4] ^ b[4*blk +: 4]);
            for (int i = 0; i < 4; i++) begin
                s[4*blk+i] = a[4*blk+i] ^ b[4*blk+i] ^ rc;
                rc         = (a[4*blk+i] & b[4*blk+i]) | (rc & (a[4*blk+i] ^ b[4*blk+i]));
            end
            blk_c = prop ? blk_c : rc;
        end
        cout = blk_c;
    end
endmodule

module add64_seq #(
    parameter int NSLICE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    input  logic [16*NSLICE-1:0]   A,
    input  logic [16*NSLICE-1:0]   B,
    input  logic                   Cin,
`ifdef ADD64_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic [16*NSLICE-1:0]   Sum,
    output logic                   Cout,
    output logic                   done,
    output logic                   busy
);
    localparam int W  = 16 * NSLICE;
    localparam int IW = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          done_q, done_d;

    logic [IW+3:0] sh;
    logic [W-1:0]  opa_sh, opb_sh, mask, ins;
    logic [15:0]   slice_a, slice_b, add_s;
    logic          add_c;
    logic [W-1:0]  b_sel;
    logic          c_sel;

    // Bit offset of the active slice; shifting avoids a variable part-select.
    assign sh      = {idx_q, 4'b0000};
    assign opa_sh  = opa_q >> sh;
    assign opb_sh  = opb_q >> sh;
    assign slice_a = opa_sh[15:0];
    assign slice_b = opb_sh[15:0];
    assign mask    = {{(W-16){1'b0}}, 16'hFFFF} << sh;
    assign ins     = {{(W-16){1'b0}}, add_s} << sh;

    cska16 u_cska (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

`ifdef ADD64_SEQ_SUB_EN
    assign b_sel = sub ? ~B : B;
    assign c_sel = sub ? 1'b1 : Cin;
`else
    assign b_sel = B;
    assign c_sel = Cin;
`endif

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d   = A;
                    opb_d   = b_sel;
                    carry_d = c_sel;
                    idx_d   = {IW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d   = (sum_q & ~mask) | ins;
                carry_d = add_c;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                cout_d  = carry_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            opa_q   <= {W{1'b0}};
            opb_q   <= {W{1'b0}};
            carry_q <= 1'b0;
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q != ST_IDLE);
    assign Sum   = sum_q;
    assign Cout  = cout_q;
    assign done  = done_q;
endmodule

// File: tb/tb_add64_seq.sv
// Directed self-checking bench for add64_seq with NSLICE=4.
module tb_add64_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [63:0] A, B;
    logic        Cin;
    logic [63:0] Sum;
    logic        Cout, done, busy;
`ifdef ADD64_SEQ_SUB_EN
    logic        sub = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add64_seq #(.NSLICE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef ADD64_SEQ_SUB_EN
        .sub   (sub),
`endif
        .Sum   (Sum),
        .Cout  (Cout),
        .done  (done),
        .busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation and wait (bounded) for done; lat=0 means no done within 10 edges.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                          output int lat, output logic [63:0] s, output logic co);
        A = a; B = b; Cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        s  = Sum;
        co = Cout;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; Cin = 1'b1;
        tick(); tick();
        n_checks++;
        if ({ready, busy, done, Cout, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'h0})
            $display("FAIL reset: ready/busy/done/Cout/Sum=%b%b%b%b %h want 1000 0", ready, busy, done, Cout, Sum);
        else n_pass++;
        start = 1'b0;
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({ready, busy, done} !== 3'b100)
            $display("FAIL reset_release: ready/busy/done=%b%b%b want 100", ready, busy, done);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [63:0] a_t [5] = '{64'h1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000};
        logic [63:0] b_t [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0FED_CBA9_8765_4321, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000};
        logic        c_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] s_t [5] = '{64'h0, 64'h2222_2222_2222_2212, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
        logic        o_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat; logic [63:0] s; logic co;
        for (int i = 0; i < 5; i++) begin
            run_op(a_t[i], b_t[i], c_t[i], lat, s, co);
            n_checks++;
            if (lat !== 5) $display("FAIL latency[%0d]: got %0d want 5", i, lat);
            else n_pass++;
            n_checks++;
            if ({co, s} !== {o_t[i], s_t[i]})
                $display("FAIL sum[%0d]: got %b %h want %b %h", i, co, s, o_t[i], s_t[i]);
            else n_pass++;
            tick();
            n_checks++;
            if (done !== 1'b0) $display("FAIL done_width[%0d]: done=%b want 0", i, done);
            else n_pass++;
        end
        // Result must persist through idle cycles.
        tick(); tick();
        n_checks++;
        if ({Cout, Sum} !== {1'b1, 64'h0}) $display("FAIL hold: got %b %h want 1 0", Cout, Sum);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int lat; logic [63:0] s; logic co;
        A = 64'h0000_0000_0000_FFFF; B = 64'h1; Cin = 1'b0; start = 1'b1;
        tick();
        n_checks++;
        if ({ready, busy} !== 2'b01) $display("FAIL busy_flags: ready/busy=%b%b want 01", ready, busy);
        else n_pass++;
        A = 64'hAAAA_AAAA_AAAA_AAAA; B = 64'h5555_5555_5555_5555; Cin = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done === 1'b1) begin lat = k; break; end
        end
        start = 1'b0;
        s = Sum; co = Cout;
        n_checks++;
        if (lat !== 5) $display("FAIL busy_latency: got %0d want 5", lat);
        else n_pass++;
        n_checks++;
        if ({co, s} !== {1'b0, 64'h0000_0000_0001_0000})
            $display("FAIL busy_ignore: got %b %h want 0 0000000000010000", co, s);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({done, ready} !== 2'b01) $display("FAIL busy_noqueue: done/ready=%b%b want 01", done, ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] ea [3];
        logic [63:0] eb [3];
        logic [64:0] exp_v;
        int n_done = 0;
        start = 1'b1;
        for (int k = 0; k < 18; k++) begin
            A = 64'h0123_4567_89AB_CDEF + 64'(k) * 64'h1000_0000_0000_0001;
            B = 64'hFEDC_BA98_7654_3210 ^ 64'(k);
            Cin = k[0];
            if (k % 6 == 0) begin ea[k/6] = A; eb[k/6] = B; end
            tick();
            n_checks++;
            if (done !== ((k % 6) == 5)) $display("FAIL b2b_done[%0d]: done=%b", k, done);
            else n_pass++;
            if ((k % 6) == 5 && done === 1'b1) begin
                exp_v = {1'b0, ea[k/6]} + {1'b0, eb[k/6]} + 65'(((k - 5) & 1));
                n_checks++;
                if ({Cout, Sum} !== exp_v)
                    $display("FAIL b2b_sum[%0d]: got %b %h want %h", k, Cout, Sum, exp_v);
                else n_pass++;
                n_done++;
            end
        end
        start = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        n_checks++;
        if (n_done !== 3) $display("FAIL b2b_count: got %0d want 3", n_done);
        else n_pass++;
    endtask

    task automatic test_abort();
        int seen = 0;
        A = 64'h1111_1111_1111_1111; B = 64'h2222_2222_2222_2222; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({ready, busy, done, Cout, Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'h0})
            $display("FAIL abort: ready/busy/done/Cout/Sum=%b%b%b%b %h want 1000 0", ready, busy, done, Cout, Sum);
        else n_pass++;
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0 || Sum !== 64'h0) $display("FAIL abort_nodone: dones=%0d Sum=%h want 0 0", seen, Sum);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, n_ok = 0, n_done = 0;
        logic [63:0] a, b, s; logic c, co;
        logic [64:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom(), $urandom()};
            b = (i % 4 == 0) ? ~a : {$urandom(), $urandom()};
            c = 1'($urandom_range(0, 1));
            exp_v = {1'b0, a} + {1'b0, b} + {64'h0, c};
            run_op(a, b, c, lat, s, co);
            if (lat == 5) n_done++;
            if ({co, s} === exp_v && lat == 5) n_ok++;
            else $display("FAIL random[%0d]: got %b %h lat %0d want %h lat 5", i, co, s, lat, exp_v);
        end
        n_checks++;
        if (n_ok !== 300) $display("FAIL random_total: matched %0d want 300", n_ok);
        else n_pass++;
        n_checks++;
        if (n_done !== 300) $display("FAIL random_dones: got %0d want 300", n_done);
        else n_pass++;
    endtask

`ifdef ADD64_SEQ_SUB_EN
    task automatic test_sub();
        int lat; logic [63:0] s; logic co;
        sub = 1'b1;
        run_op(64'd5, 64'd7, 1'b0, lat, s, co);
        n_checks++;
        if ({co, s} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) $display("FAIL sub_borrow: got %b %h", co, s);
        else n_pass++;
        run_op(64'd7, 64'd5, 1'b0, lat, s, co);
        n_checks++;
        if ({co, s} !== {1'b1, 64'd2}) $display("FAIL sub_noborrow: got %b %h", co, s);
        else n_pass++;
        sub = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; A = 64'h0; B = 64'h0; Cin = 1'b0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef ADD64_SEQ_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
